// File: rtl/alu_mdu.sv
// alu_mdu: RV32I base ALU plus RV32M multiply/divide unit behind a
// valid/ready handshake. Base ops answer one cycle after accept; MUL/DIV/REM
// iterate for WIDTH cycles using a shift-add multiplier or restoring divider.
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t               state_q, state_d;
   logic [SHW:0]         cnt_q, cnt_d;
   logic [3:0]           op_q, op_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic                 neg_q, neg_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [WIDTH-1:0]     resp_data_q, resp_data_d;

   // Two's-complement negation helpers, kept separate from the datapath.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return ~x + 1'b1;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      return ~x + 1'b1;
   endfunction

   // Single-cycle base integer operations; shifts use only the low SHW bits of b.
   function automatic logic [WIDTH-1:0] alu_base(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [SHW-1:0] sh;
      logic signed [WIDTH-1:0] sa;
      sh = b[SHW-1:0];
      sa = $signed(a);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a << sh;
         3'd2:    return $unsigned(sa >>> sh);
         3'd3:    return a - b;
         3'd4:    return a ^ b;
         3'd5:    return a >> sh;
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   // Operand classification at accept time.
   logic             a_signed, b_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             is_div, div_zero, div_ovf;

   always_comb begin
      // mul and the unsigned variants treat operands as plain magnitudes
      a_signed = (req_op == 4'd9) || (req_op == 4'd10) ||
                 (req_op == 4'd12) || (req_op == 4'd14);
      b_signed = (req_op == 4'd9) || (req_op == 4'd12) || (req_op == 4'd14);
      a_neg    = a_signed & req_a[WIDTH-1];
      b_neg    = b_signed & req_b[WIDTH-1];
      a_mag    = a_neg ? neg_w(req_a) : req_a;
      b_mag    = b_neg ? neg_w(req_b) : req_b;
      is_div   = req_op[3] & req_op[2];
      div_zero = (req_b == '0);
      div_ovf  = ~req_op[0] & (req_a == MOST_NEG) & (req_b == '1);
   end

   // One multiply or divide iteration plus the sign-corrected final result.
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]   mul_next, div_next, step_next, prod;
   logic [WIDTH-1:0]     quo, rem, md_result;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      if (!div_diff[WIDTH])
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      step_next = op_q[2] ? div_next : mul_next;

      prod = neg_q ? neg_2w(mul_next) : mul_next;
      quo  = neg_q ? neg_w(div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
      rem  = neg_q ? neg_w(div_next[2*WIDTH-1:WIDTH]) : div_next[2*WIDTH-1:WIDTH];
      if (op_q[2])
         md_result = op_q[1] ? rem : quo;
      else
         md_result = (op_q[1:0] == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
   end

   // Next-state and datapath update; flush overrides everything.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      acc_d        = acc_q;
      opb_d        = opb_q;
      neg_d        = neg_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      if (flush) begin
         state_d      = S_IDLE;
         resp_valid_d = 1'b0;
         cnt_d        = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  if (!req_op[3]) begin
                     resp_data_d  = alu_base(req_op[2:0], req_a, req_b);
                     resp_valid_d = 1'b1;
                     state_d      = S_DONE;
                  end else if (is_div && div_zero) begin
                     resp_data_d  = req_op[1] ? req_a : '1;
                     resp_valid_d = 1'b1;
                     state_d      = S_DONE;
                  end else if (is_div && div_ovf) begin
                     resp_data_d  = req_op[1] ? '0 : req_a;
                     resp_valid_d = 1'b1;
                     state_d      = S_DONE;
                  end else begin
                     op_d    = req_op;
                     cnt_d   = (SHW+1)'(WIDTH);
                     state_d = S_CALC;
                     if (is_div) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        opb_d = b_mag;
                        neg_d = req_op[1] ? a_neg : (a_neg ^ b_neg);
                     end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                        opb_d = a_mag;
                        neg_d = a_neg ^ b_neg;
                     end
                  end
               end
            end
            S_CALC: begin
               acc_d = step_next;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == (SHW+1)'(1)) begin
                  resp_data_d  = md_result;
                  resp_valid_d = 1'b1;
                  state_d      = S_DONE;
               end
            end
            default: begin
               if (resp_ready) begin
                  resp_valid_d = 1'b0;
                  state_d      = S_IDLE;
               end
            end
         endcase
      end
   end

   // State register with asynchronous reset; an in-flight op is discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         acc_q        <= '0;
         opb_q        <= '0;
         neg_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         acc_q        <= acc_d;
         opb_q        <= opb_d;
         neg_q        <= neg_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE) & ~flush;
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

endmodule
